fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Packet-level round-robin arbiter that shares the write port of one `dc_fifo` among `NREQ` requesters in the FIFO's write-clock domain. It grants the FIFO to one requester for a whole packet, but only when the FIFO has room for a maximum-size packet, so packets are never interleaved and never split by `fifo_full`. Its FIFO-side outputs connect directly to `wr_din`, `wr_write`, `wr_full` and `wr_usedw`. It is the only writer of that FIFO.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `DW`, 16: payload width; equals `$bits(T)` of the attached FIFO.
- `L2DEPTH`, 3: same value as the attached FIFO. Capacity is 2**L2DEPTH-1 entries.
- `MAX_PKT`, 4: maximum beats per packet. Elaboration fails with `$fatal` unless 1 ≤ MAX_PKT ≤ 2**L2DEPTH-1.

Ports:
- `clk` in 1: the FIFO write clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: per-requester beat valid.
- `req_data` in NREQ*DW: requester i's beat occupies bits [i*DW +: DW].
- `req_last` in NREQ: marks the final beat of a packet.
- `req_ready` out NREQ: beat accepted when valid and ready are both high.
- `fifo_din` out DW: to FIFO `wr_din`.
- `fifo_write` out 1: to FIFO `wr_write`.
- `fifo_full` in 1: from FIFO `wr_full`.
- `fifo_usedw` in L2DEPTH: from FIFO `wr_usedw`.
- `grant_id` out $clog2(NREQ): current or most recent grantee.
- `busy` out 1: high while in XFER.
- `err_oversize` out 1: one-cycle pulse when a packet is truncated at MAX_PKT.

## Operation
- The block has two states, IDLE and XFER. Reset puts it in IDLE with `last_grant`=NREQ-1, `grant_id`=0, beat count 0 and `err_oversize`=0.
- Output values while in reset: all `req_ready`=0, `fifo_write`=0, `fifo_din`=0, `busy`=0.
- **space** = (2**L2DEPTH-1) - `fifo_usedw`, computed at L2DEPTH+1 bits, unsigned.
- **IDLE:**
  - `req_ready`=0 and `fifo_write`=0.
  - If any `req_valid` is high, space ≥ MAX_PKT and `fifo_full`=0: pick the first valid requester searching from `last_grant`+1 modulo NREQ, with wrap-around.
  - On the next edge: `grant_id` gets the winner, beat count is cleared, state goes to XFER.
- **XFER** (g = `grant_id`):
  - `req_ready[g]` = !`fifo_full`; all other ready bits are 0.
  - `fifo_write` = `req_valid[g]` & !`fifo_full`.
  - `fifo_din` = `req_data[g]`; it is 0 in IDLE.
  - These outputs are combinational from the inputs and state.
  - Each accepted beat increments the beat count.
- **Leaving XFER:** on an accepted beat with `req_last[g]`=1, or when the accepted beat is number MAX_PKT:
  - State returns to IDLE and `last_grant` gets g.
  - If beat MAX_PKT was accepted without `req_last`, `err_oversize` pulses for one cycle after that edge. The requester's following beats are arbitrated as a new packet.
- **Stall:** if `req_valid[g]` drops mid-packet, the grant is held indefinitely. `busy` stays 1 and nothing is written.
- **`fifo_full` in XFER:** it cannot assert given the space check and a single writer. It is still honoured: writes and ready are gated, and the state is held.
- **Simultaneous events:** a new request arriving during XFER waits. An exit beat and a competing request in the same cycle give one IDLE cycle, then arbitration.
- Asserting `rstn` mid-packet aborts the packet immediately. Beats already written remain in the FIFO; the FIFO's own reset is the system's responsibility.

## Timing
- **Grant latency:** valid first seen in IDLE at cycle n gives XFER and a ready beat in cycle n+1. With continuous valid, a packet of B beats writes during cycles n+1..n+B.
- **Packet gap:** the last beat at cycle k gives IDLE in cycle k+1, and the next packet's first write is at k+2. Minimum overhead is one cycle per packet.
- **Space check:** `fifo_usedw` is updated on the same edge as each write. In IDLE it therefore includes every beat written, and is conservative with respect to reads in flight through the gray synchroniser.
- **Outputs:** `grant_id`, `busy` and `err_oversize` are registered.

## Test plan
1. **Single packet:** reset, FIFO empty (space 7); req 0 sends a 3-beat packet (0xA1, 0xA2, 0xA3, last on the third).
   - `grant_id`=0 one cycle after valid.
   - Three consecutive `fifo_write` pulses carrying those values, in order.
   - `busy` falls the cycle after 0xA3.
2. **Round robin:** all four requesters continuously valid with 2-beat packets.
   - Grant order 0,1,2,3,0,1.
   - Each packet is 2 writes followed by exactly 1 idle cycle.
3. **Space gating:** hold `fifo_usedw`=4 (space 3 < 4) with req 1 valid.
   - No grant for 10 cycles.
   - Set `fifo_usedw`=3: grant to 1 on the next edge.
4. **Oversize:** req 2 sends 6 beats with last on the 6th.
   - After beat 4: `err_oversize` pulses once and state goes to IDLE.
   - Req 2 is re-granted; beats 5 and 6 are written and the grant ends on last.
5. **Stall:** granted req 3 drops valid for 3 cycles after its first beat.
   - `busy`=1, no writes, no other grant.
   - Remaining beats are written when valid returns.
6. **Reset mid-packet:** assert `rstn` low during XFER, asynchronously to `clk`.
   - `req_ready`, `fifo_write` and `busy` are 0 immediately.
   - After release with reqs 0 and 2 valid: first grant goes to 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Packet-level round-robin arbiter sharing the write port of one dc_fifo among
// NREQ requesters, all in the FIFO write-clock domain. A requester owns the
// FIFO for a whole packet, and is only granted when the FIFO has room for a
// maximum-size packet. Packets are therefore never interleaved and never split
// by fifo_full.
//
// Handshake: a beat on requester i transfers on a rising clk edge where
// req_valid[i] and req_ready[i] are both high. req_valid may rise or fall at
// any time. req_data/req_last are only looked at while req_valid is high.
// fifo_write is high exactly on cycles where a beat transfers.
//
// Ports:
//   clk          in   FIFO write clock
//   rstn         in   asynchronous active-low reset
//   req_valid    in   [NREQ]      per-requester beat valid
//   req_data     in   [NREQ*DW]   requester i beat in [i*DW +: DW]
//   req_last     in   [NREQ]      final beat of a packet
//   req_ready    out  [NREQ]      beat accepted when valid & ready
//   fifo_din     out  [DW]        to FIFO wr_din (0 while idle)
//   fifo_write   out              to FIFO wr_write
//   fifo_full    in               from FIFO wr_full
//   fifo_usedw   in   [L2DEPTH]   from FIFO wr_usedw
//   grant_id     out  [clog2(NREQ)] current or most recent grantee
//   busy         out              high while a packet is in progress
//   err_oversize out              1-cycle pulse when a packet is cut at MAX_PKT
//   state_dbg    out              raw FSM state (0 = IDLE, 1 = XFER)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 16,
   parameter int L2DEPTH = 3,
   parameter int MAX_PKT = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DW-1:0]       req_data,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          req_ready,
   output logic [DW-1:0]            fifo_din,
   output logic                     fifo_write,
   input  logic                     fifo_full,
   input  logic [L2DEPTH-1:0]       fifo_usedw,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     busy,
   output logic                     err_oversize,
   output logic                     state_dbg
);

   localparam int GW  = $clog2(NREQ);
   localparam int CAP = (2 ** L2DEPTH) - 1;
   localparam int CW  = $clog2(MAX_PKT + 1);

   localparam logic [L2DEPTH:0] CAP_V = CAP[L2DEPTH:0];
   localparam logic [L2DEPTH:0] MAX_V = MAX_PKT[L2DEPTH:0];
   localparam logic [CW-1:0]    MAX_C = CW'(MAX_PKT);

   // A packet must fit in an empty FIFO, otherwise nobody could ever be granted.
   if (MAX_PKT < 1 || MAX_PKT > CAP) begin : g_bad_max_pkt
      $fatal(1, "fifo_wr_arbiter: MAX_PKT must be in 1..2**L2DEPTH-1");
   end

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   state_t          state;
   logic [GW-1:0]   last_grant;
   logic [GW-1:0]   winner;
   logic            found;
   int              idx;
   logic [CW-1:0]   beat_cnt;
   logic [CW-1:0]   beat_next;
   logic [L2DEPTH:0] space;
   logic            can_grant;
   logic            accept;
   logic            pkt_end;

   // Free entries. usedw already counts every beat we wrote (same-edge update),
   // and lags reads in flight through the synchroniser, so this never overstates.
   assign space     = CAP_V - {1'b0, fifo_usedw};
   assign can_grant = (|req_valid) && (space >= MAX_V) && !fifo_full;

   // Round-robin pick: first valid requester after last_grant, wrapping.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx[GW-1:0]]) begin
            winner = GW'(idx);
            found  = 1'b1;
         end
      end
   end

   // Write-side datapath is combinational from state and inputs so a beat can
   // move every cycle. fifo_full is honoured even though the space check means
   // it should not assert during a packet.
   always_comb begin
      req_ready  = '0;
      fifo_write = 1'b0;
      fifo_din   = '0;
      if (state == XFER) begin
         req_ready[grant_id] = !fifo_full;
         fifo_write          = req_valid[grant_id] && !fifo_full;
         fifo_din            = req_data[grant_id*DW +: DW];
      end
   end

   assign accept    = fifo_write;
   assign beat_next = beat_cnt + CW'(1);
   // Packet ends on an explicit last, or is cut when it reaches MAX_PKT beats.
   assign pkt_end   = accept && (req_last[grant_id] || (beat_next == MAX_C));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         last_grant   <= GW'(NREQ - 1);
         grant_id     <= '0;
         beat_cnt     <= '0;
         err_oversize <= 1'b0;
      end else begin
         err_oversize <= 1'b0;
         case (state)
            IDLE: begin
               if (can_grant) begin
                  grant_id <= winner;
                  beat_cnt <= '0;
                  state    <= XFER;
               end
            end
            XFER: begin
               if (pkt_end) begin
                  state        <= IDLE;
                  last_grant   <= grant_id;
                  beat_cnt     <= '0;
                  // Truncation: remaining beats come back as a new packet.
                  err_oversize <= !req_last[grant_id];
               end else if (accept) begin
                  beat_cnt <= beat_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state == XFER);
   assign state_dbg = state;

endmodule
